// File: rtl/pxl_line_cache.sv
`default_nettype none
// ============================================================================
// Module   : pxl_line_cache
// Purpose  : Four-line ring buffer of captured GBA pixels, presenting a
//            registered 3x3 RGB neighbourhood around column curPxl of the
//            current read line to the HDMI image generator.
// Options  : LINE_CACHE_EDGE_ZERO_EN - when defined, neighbours outside the
//            frame read as black instead of replicating the nearest sample.
// Revision : 1.0 - initial release
// ============================================================================
module pxl_line_cache #(
  parameter int LINEWIDTH = 240,
  parameter int LINES     = 160
) (
  input  logic        pxlClk,
  input  logic        rstN,
  input  logic        wrEn,
  input  logic [23:0] wrPxl,
  input  logic        newFrameIn,
  input  logic        nextLine,
  input  logic        cacheUpdate,
  input  logic [7:0]  curPxl,
  output logic [7:0]  prevLinePrevPxlRedOut,
  output logic [7:0]  prevLinePrevPxlGreenOut,
  output logic [7:0]  prevLinePrevPxlBlueOut,
  output logic [7:0]  prevLineCurPxlRedOut,
  output logic [7:0]  prevLineCurPxlGreenOut,
  output logic [7:0]  prevLineCurPxlBlueOut,
  output logic [7:0]  prevLineNextPxlRedOut,
  output logic [7:0]  prevLineNextPxlGreenOut,
  output logic [7:0]  prevLineNextPxlBlueOut,
  output logic [7:0]  curLinePrevPxlRedOut,
  output logic [7:0]  curLinePrevPxlGreenOut,
  output logic [7:0]  curLinePrevPxlBlueOut,
  output logic [7:0]  curLineCurPxlRedOut,
  output logic [7:0]  curLineCurPxlGreenOut,
  output logic [7:0]  curLineCurPxlBlueOut,
  output logic [7:0]  curLineNextPxlRedOut,
  output logic [7:0]  curLineNextPxlGreenOut,
  output logic [7:0]  curLineNextPxlBlueOut,
  output logic [7:0]  nextLinePrevPxlRedOut,
  output logic [7:0]  nextLinePrevPxlGreenOut,
  output logic [7:0]  nextLinePrevPxlBlueOut,
  output logic [7:0]  nextLineCurPxlRedOut,
  output logic [7:0]  nextLineCurPxlGreenOut,
  output logic [7:0]  nextLineCurPxlBlueOut,
  output logic [7:0]  nextLineNextPxlRedOut,
  output logic [7:0]  nextLineNextPxlGreenOut,
  output logic [7:0]  nextLineNextPxlBlueOut,
  output logic        sameLine,
  output logic        newFrameOut,
  output logic        overflow
);

  // Line counters must hold LINES itself ("frame complete").
  localparam int              c_LW        = $clog2(LINES + 1);
  localparam logic [c_LW-1:0] c_LINES     = c_LW'(LINES);
  localparam logic [c_LW-1:0] c_LAST_LINE = c_LW'(LINES - 1);
  localparam logic [c_LW-1:0] c_ONE       = c_LW'(1);
  localparam logic [c_LW-1:0] c_TWO       = c_LW'(2);
  localparam logic [7:0]      c_LAST_COL  = 8'(LINEWIDTH - 1);

  // Line n lives in buffer n mod 4.
  logic [23:0]     r_mem [0:3][0:LINEWIDTH-1];

  logic [7:0]      r_wr_x;
  logic [c_LW-1:0] r_wr_line;
  logic [c_LW-1:0] r_rd_line;
  logic            r_new_frame;
  logic            r_overflow;
  logic            r_same_line;
  logic [23:0]     r_win [0:2][0:2];

  logic            w_frame_start;
  logic [7:0]      w_wr_x_base;
  logic [c_LW-1:0] w_wr_line_base;
  logic [c_LW-1:0] w_rd_line_base;
  logic            w_wr_ok;
  logic            w_wr_accept;
  logic            w_wr_refuse;
  logic [7:0]      w_wr_x_nxt;
  logic [c_LW-1:0] w_wr_line_nxt;
  logic [c_LW-1:0] w_rd_line_nxt;
  logic            w_same_nxt;

  logic [7:0]      w_col_cur;
  logic [7:0]      w_col_idx [0:2];
  logic [1:0]      w_row_buf [0:2];
  logic [23:0]     w_sample  [0:2][0:2];
`ifdef LINE_CACHE_EDGE_ZERO_EN
  logic            w_row_oob [0:2];
  logic            w_col_oob [0:2];
`endif

  // Frame start is a rising edge of newFrameIn; it overrides the counters
  // for this cycle so a coincident write lands at line 0, column 0.
  always_comb begin
    w_frame_start  = newFrameIn & ~r_new_frame;
    w_wr_x_base    = w_frame_start ? 8'd0 : r_wr_x;
    w_wr_line_base = w_frame_start ? '0 : r_wr_line;
    w_rd_line_base = w_frame_start ? '0 : r_rd_line;

    // The writer may run at most two lines ahead of the reader, so the
    // prev-line buffer is never overwritten while it is still in the window.
    w_wr_ok     = (w_wr_line_base < c_LINES) &&
                  (w_wr_line_base <= w_rd_line_base + c_TWO);
    w_wr_accept = wrEn & w_wr_ok;
    w_wr_refuse = wrEn & ~w_wr_ok;

    w_wr_x_nxt    = w_wr_x_base;
    w_wr_line_nxt = w_wr_line_base;
    if (w_wr_accept) begin
      if (w_wr_x_base == c_LAST_COL) begin
        w_wr_x_nxt    = 8'd0;
        w_wr_line_nxt = w_wr_line_base + c_ONE;
      end else begin
        w_wr_x_nxt    = w_wr_x_base + 8'd1;
      end
    end

    // Read line saturates at the last line of the frame.
    w_rd_line_nxt = w_rd_line_base;
    if (nextLine && !w_frame_start && (r_rd_line < c_LAST_LINE)) begin
      w_rd_line_nxt = r_rd_line + c_ONE;
    end

    // The line following the (post-step) read line is incomplete.
    w_same_nxt = (w_wr_line_base <= w_rd_line_nxt + c_ONE) &&
                 (w_rd_line_nxt < c_LAST_LINE);
  end

  // Pixel storage; no reset so it maps onto RAM-style storage.
  always_ff @(posedge pxlClk) begin
    if (w_wr_accept) begin
      r_mem[w_wr_line_base[1:0]][w_wr_x_base] <= wrPxl;
    end
  end

  // Write/read counters, frame-edge detector and status flags.
  always_ff @(posedge pxlClk or negedge rstN) begin
    if (!rstN) begin
      r_wr_x      <= 8'd0;
      r_wr_line   <= '0;
      r_rd_line   <= '0;
      r_new_frame <= 1'b0;
      r_overflow  <= 1'b0;
      r_same_line <= 1'b1;
    end else begin
      r_wr_x      <= w_wr_x_nxt;
      r_wr_line   <= w_wr_line_nxt;
      r_rd_line   <= w_rd_line_nxt;
      r_new_frame <= newFrameIn;
      if (w_frame_start) begin
        r_overflow <= 1'b0;
      end else if (w_wr_refuse) begin
        r_overflow <= 1'b1;
      end
      if (cacheUpdate) begin
        r_same_line <= w_same_nxt;
      end
    end
  end

  // Neighbour addressing with column clamp and frame-edge handling.
  always_comb begin
    w_col_cur    = (curPxl > c_LAST_COL) ? c_LAST_COL : curPxl;
    w_col_idx[1] = w_col_cur;
    w_col_idx[0] = (w_col_cur == 8'd0) ? w_col_cur : w_col_cur - 8'd1;
    w_col_idx[2] = (w_col_cur == c_LAST_COL) ? w_col_cur : w_col_cur + 8'd1;

    // Only the low two bits of the line number select a buffer; mod-4
    // arithmetic on those bits gives the neighbouring buffers directly.
    w_row_buf[1] = r_rd_line[1:0];
    w_row_buf[0] = (r_rd_line == '0) ? r_rd_line[1:0] : r_rd_line[1:0] - 2'd1;
    w_row_buf[2] = (r_rd_line == c_LAST_LINE) ? r_rd_line[1:0]
                                              : r_rd_line[1:0] + 2'd1;
`ifdef LINE_CACHE_EDGE_ZERO_EN
    w_col_oob[0] = (w_col_cur == 8'd0);
    w_col_oob[1] = 1'b0;
    w_col_oob[2] = (w_col_cur == c_LAST_COL);
    w_row_oob[0] = (r_rd_line == '0);
    w_row_oob[1] = 1'b0;
    w_row_oob[2] = (r_rd_line == c_LAST_LINE);
`endif

    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w_sample[r][c] = r_mem[w_row_buf[r]][w_col_idx[c]];
`ifdef LINE_CACHE_EDGE_ZERO_EN
        if (w_row_oob[r] || w_col_oob[c]) begin
          w_sample[r][c] = 24'd0;
        end
`endif
      end
    end
  end

  // Registered 3x3 window, one cycle behind curPxl and the read line.
  always_ff @(posedge pxlClk or negedge rstN) begin
    if (!rstN) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win[r][c] <= 24'd0;
        end
      end
    end else begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win[r][c] <= w_sample[r][c];
        end
      end
    end
  end

  assign sameLine    = r_same_line;
  assign newFrameOut = r_new_frame;
  assign overflow    = r_overflow;

  assign prevLinePrevPxlRedOut   = r_win[0][0][23:16];
  assign prevLinePrevPxlGreenOut = r_win[0][0][15:8];
  assign prevLinePrevPxlBlueOut  = r_win[0][0][7:0];
  assign prevLineCurPxlRedOut    = r_win[0][1][23:16];
  assign prevLineCurPxlGreenOut  = r_win[0][1][15:8];
  assign prevLineCurPxlBlueOut   = r_win[0][1][7:0];
  assign prevLineNextPxlRedOut   = r_win[0][2][23:16];
  assign prevLineNextPxlGreenOut = r_win[0][2][15:8];
  assign prevLineNextPxlBlueOut  = r_win[0][2][7:0];
  assign curLinePrevPxlRedOut    = r_win[1][0][23:16];
  assign curLinePrevPxlGreenOut  = r_win[1][0][15:8];
  assign curLinePrevPxlBlueOut   = r_win[1][0][7:0];
  assign curLineCurPxlRedOut     = r_win[1][1][23:16];
  assign curLineCurPxlGreenOut   = r_win[1][1][15:8];
  assign curLineCurPxlBlueOut    = r_win[1][1][7:0];
  assign curLineNextPxlRedOut    = r_win[1][2][23:16];
  assign curLineNextPxlGreenOut  = r_win[1][2][15:8];
  assign curLineNextPxlBlueOut   = r_win[1][2][7:0];
  assign nextLinePrevPxlRedOut   = r_win[2][0][23:16];
  assign nextLinePrevPxlGreenOut = r_win[2][0][15:8];
  assign nextLinePrevPxlBlueOut  = r_win[2][0][7:0];
  assign nextLineCurPxlRedOut    = r_win[2][1][23:16];
  assign nextLineCurPxlGreenOut  = r_win[2][1][15:8];
  assign nextLineCurPxlBlueOut   = r_win[2][1][7:0];
  assign nextLineNextPxlRedOut   = r_win[2][2][23:16];
  assign nextLineNextPxlGreenOut = r_win[2][2][15:8];
  assign nextLineNextPxlBlueOut  = r_win[2][2][7:0];

endmodule
`default_nettype wire

// File: tb/tb_pxl_line_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_pxl_line_cache
// Purpose  : Self-checking bench for pxl_line_cache. A frame-image model
//            (indexed by absolute line number) predicts the window and flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pxl_line_cache;

  localparam int LW = 240;
  localparam int LN = 160;
`ifdef LINE_CACHE_EDGE_ZERO_EN
  localparam bit ZM = 1'b1;
`else
  localparam bit ZM = 1'b0;
`endif

  logic        pxlClk = 1'b0;
  logic        rstN = 1'b0;
  logic        wrEn = 1'b0;
  logic [23:0] wrPxl = 24'd0;
  logic        newFrameIn = 1'b0;
  logic        nextLine = 1'b0;
  logic        cacheUpdate = 1'b0;
  logic [7:0]  curPxl = 8'd0;

  logic [7:0] pPR, pPG, pPB, pCR, pCG, pCB, pNR, pNG, pNB;
  logic [7:0] cPR, cPG, cPB, cCR, cCG, cCB, cNR, cNG, cNB;
  logic [7:0] nPR, nPG, nPB, nCR, nCG, nCB, nNR, nNG, nNB;
  logic       sameLine, newFrameOut, overflow;

  always #5 pxlClk = ~pxlClk;

  pxl_line_cache #(.LINEWIDTH(LW), .LINES(LN)) dut (
    .pxlClk(pxlClk), .rstN(rstN), .wrEn(wrEn), .wrPxl(wrPxl),
    .newFrameIn(newFrameIn), .nextLine(nextLine), .cacheUpdate(cacheUpdate),
    .curPxl(curPxl),
    .prevLinePrevPxlRedOut(pPR), .prevLinePrevPxlGreenOut(pPG), .prevLinePrevPxlBlueOut(pPB),
    .prevLineCurPxlRedOut(pCR),  .prevLineCurPxlGreenOut(pCG),  .prevLineCurPxlBlueOut(pCB),
    .prevLineNextPxlRedOut(pNR), .prevLineNextPxlGreenOut(pNG), .prevLineNextPxlBlueOut(pNB),
    .curLinePrevPxlRedOut(cPR),  .curLinePrevPxlGreenOut(cPG),  .curLinePrevPxlBlueOut(cPB),
    .curLineCurPxlRedOut(cCR),   .curLineCurPxlGreenOut(cCG),   .curLineCurPxlBlueOut(cCB),
    .curLineNextPxlRedOut(cNR),  .curLineNextPxlGreenOut(cNG),  .curLineNextPxlBlueOut(cNB),
    .nextLinePrevPxlRedOut(nPR), .nextLinePrevPxlGreenOut(nPG), .nextLinePrevPxlBlueOut(nPB),
    .nextLineCurPxlRedOut(nCR),  .nextLineCurPxlGreenOut(nCG),  .nextLineCurPxlBlueOut(nCB),
    .nextLineNextPxlRedOut(nNR), .nextLineNextPxlGreenOut(nNG), .nextLineNextPxlBlueOut(nNB),
    .sameLine(sameLine), .newFrameOut(newFrameOut), .overflow(overflow)
  );

  // Window index k = row*3 + col, row/col 0 = prev, 1 = cur, 2 = next.
  logic [23:0] dut_win [0:8];
  assign dut_win[0] = {pPR, pPG, pPB};
  assign dut_win[1] = {pCR, pCG, pCB};
  assign dut_win[2] = {pNR, pNG, pNB};
  assign dut_win[3] = {cPR, cPG, cPB};
  assign dut_win[4] = {cCR, cCG, cCB};
  assign dut_win[5] = {cNR, cNG, cNB};
  assign dut_win[6] = {nPR, nPG, nPB};
  assign dut_win[7] = {nCR, nCG, nCB};
  assign dut_win[8] = {nNR, nNG, nNB};

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] pat(input int ln, input int col);
    return {col[7:0], ln[7:0], 8'h11};
  endfunction

  // ---------------- behavioural model ----------------
  logic [23:0] img [0:LN-1][0:LW-1];
  int          m_wl, m_wx, m_rl;
  bit          m_ov, m_nf, m_same, m_win_ok, m_live;
  logic [23:0] e_win [0:8];
  bit          t_fs;
  int          t_wlc, t_need, t_cx;

  // Neighbour (dr,dc) of frame pixel (rl,cx) with the frame-edge rule.
  function automatic logic [23:0] nb(input int rl, input int cx, input int dr, input int dc);
    int r, c;
    bit oob;
    r = rl + dr;
    c = cx + dc;
    oob = (r < 0) || (r > LN - 1) || (c < 0) || (c > LW - 1);
    if (ZM && oob) return 24'd0;
    if ((r < 0) || (r > LN - 1)) r = rl;
    if ((c < 0) || (c > LW - 1)) c = cx;
    return img[r][c];
  endfunction

  initial begin
    m_live = 1'b0;
    forever begin
      @(posedge pxlClk or negedge rstN);
      if (!rstN) begin
        m_wl = 0; m_wx = 0; m_rl = 0;
        m_ov = 1'b0; m_nf = 1'b0; m_same = 1'b1;
        m_win_ok = 1'b1;
        for (int k = 0; k < 9; k++) e_win[k] = 24'd0;
        m_live = 1'b1;
      end else begin
        // Window seen by the consumer reflects the state before this edge.
        t_cx = (int'(curPxl) > LW - 1) ? LW - 1 : int'(curPxl);
        for (int k = 0; k < 9; k++) e_win[k] = nb(m_rl, t_cx, k / 3 - 1, k % 3 - 1);
        t_need = (m_rl < LN - 1) ? m_rl + 1 : m_rl;
        m_win_ok = (t_need < m_wl);

        t_fs = newFrameIn && !m_nf;
        if (t_fs) begin
          m_wl = 0; m_wx = 0; m_rl = 0; m_ov = 1'b0;
        end
        t_wlc = m_wl;
        if (wrEn) begin
          if ((m_wl < LN) && (m_wl <= m_rl + 2)) begin
            img[m_wl][m_wx] = wrPxl;
            m_wx++;
            if (m_wx == LW) begin
              m_wx = 0;
              m_wl++;
            end
          end else begin
            m_ov = 1'b1;
          end
        end
        if (nextLine && !t_fs && (m_rl < LN - 1)) m_rl++;
        if (cacheUpdate) m_same = (t_wlc <= m_rl + 1) && (m_rl < LN - 1);
        m_nf = newFrameIn;
      end
    end
  end

  // Compare DUT against the model every cycle on the falling edge.
  initial begin
    forever begin
      @(negedge pxlClk);
      if (m_live) begin
        check("sameLine", {23'd0, sameLine}, {23'd0, m_same});
        check("overflow", {23'd0, overflow}, {23'd0, m_ov});
        check("newFrameOut", {23'd0, newFrameOut}, {23'd0, m_nf});
        if (m_win_ok) begin
          for (int k = 0; k < 9; k++) check($sformatf("win%0d", k), dut_win[k], e_win[k]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wr_cols(input int ln, input int n);
    for (int c = 0; c < n; c++) begin
      wrEn   = 1'b1;
      wrPxl  = pat(ln, c);
      curPxl = 8'((c * 7) % 256);
      @(negedge pxlClk);
    end
    wrEn = 1'b0;
  endtask

  task automatic pulse_next();
    nextLine = 1'b1;
    @(negedge pxlClk);
    nextLine = 1'b0;
  endtask

  task automatic pulse_cu();
    cacheUpdate = 1'b1;
    @(negedge pxlClk);
    cacheUpdate = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge pxlClk);
    rstN = 1'b1;
    check("rst_sameLine", {23'd0, sameLine}, 24'd1);
    check("rst_overflow", {23'd0, overflow}, 24'd0);
    check("rst_curCurRed", {16'd0, cCR}, 24'd0);

    // Line 0 only: next line incomplete.
    wr_cols(0, LW);
    pulse_cu();
    check("same_line0_only", {23'd0, sameLine}, 24'd1);

    // Line 1 complete: window around column 5.
    wr_cols(1, LW);
    curPxl = 8'd5;
    pulse_cu();
    check("same_line1_done", {23'd0, sameLine}, 24'd0);
    check("c5_curCurRed", {16'd0, cCR}, 24'd5);
    check("c5_curPrevRed", {16'd0, cPR}, 24'd4);
    check("c5_prevCurRed", {16'd0, pCR}, ZM ? 24'd0 : 24'd5);
    check("c5_nextCurGreen", {16'd0, nCG}, 24'd1);
    curPxl = 8'd0;
    @(negedge pxlClk);
    check("c0_curPrevBlue", {16'd0, cPB}, ZM ? 24'd0 : 24'h11);
    curPxl = 8'd250;
    @(negedge pxlClk);
    check("clamp_curCurRed", {16'd0, cCR}, 24'd239);
    check("clamp_curNextRed", {16'd0, cNR}, ZM ? 24'd0 : 24'd239);

    // Lines 0..2 present with rdLine 0: further writes are refused.
    wr_cols(2, LW);
    wr_cols(3, 3);
    check("ovf_set", {23'd0, overflow}, 24'd1);
    curPxl = 8'd5;
    @(negedge pxlClk);
    check("line0_kept", {cCR, cCG, cCB}, 24'h050011);

    // Step once, then line 3 is accepted.
    pulse_next();
    wr_cols(3, LW);
    curPxl = 8'd7;
    @(negedge pxlClk);
    check("r1_prevGreen", {16'd0, pCG}, 24'd0);
    check("r1_curGreen", {16'd0, cCG}, 24'd1);
    check("r1_nextGreen", {16'd0, nCG}, 24'd2);
    check("ovf_sticky", {23'd0, overflow}, 24'd1);
    pulse_next();
    curPxl = 8'd1;
    @(negedge pxlClk);
    check("line3_col1", {nCR, nCG, nCB}, 24'h010311);

    // Advance to wrLine 80, rdLine 78.
    for (int ln = 4; ln < 80; ln++) begin
      wr_cols(ln, LW);
      pulse_next();
    end

    // Frame start together with nextLine: frame start wins.
    newFrameIn = 1'b1;
    nextLine   = 1'b1;
    @(negedge pxlClk);
    nextLine   = 1'b0;
    check("fs_newFrameOut", {23'd0, newFrameOut}, 24'd1);
    check("fs_overflow", {23'd0, overflow}, 24'd0);
    pulse_cu();
    check("fs_sameLine", {23'd0, sameLine}, 24'd1);
    curPxl = 8'd0;
    wrEn = 1'b1;
    wrPxl = 24'hABCDEF;
    @(negedge pxlClk);
    wrEn = 1'b0;
    @(negedge pxlClk);
    check("fs_first_write", {cCR, cCG, cCB}, 24'hABCDEF);
    check("fs_rd_zero_prev", {pCR, pCG, pCB}, ZM ? 24'd0 : 24'hABCDEF);

    // Full frame; first pixel coincides with the frame-start edge.
    newFrameIn = 1'b0;
    @(negedge pxlClk);
    newFrameIn = 1'b1;
    wr_cols(0, LW);
    wr_cols(1, LW);
    wr_cols(2, LW);
    for (int ln = 3; ln < LN; ln++) begin
      pulse_next();
      wr_cols(ln, LW);
    end
    repeat (3) pulse_next();
    curPxl = 8'd239;
    @(negedge pxlClk);
    check("last_curGreen", {16'd0, cCG}, 24'd159);
    check("last_prevGreen", {16'd0, pCG}, 24'd158);
    check("last_nextGreen", {16'd0, nCG}, ZM ? 24'd0 : 24'd159);
    check("last_curNextRed", {16'd0, cNR}, ZM ? 24'd0 : 24'd239);
    check("last_nextNext", {nNR, nNG, nNB}, ZM ? 24'd0 : 24'hEF9F11);
    pulse_cu();
    check("last_sameLine", {23'd0, sameLine}, 24'd0);
    wr_cols(0, 1);
    check("full_frame_ovf", {23'd0, overflow}, 24'd1);

    // Asynchronous reset in the middle of a line (wrX = 100).
    newFrameIn = 1'b0;
    @(negedge pxlClk);
    newFrameIn = 1'b1;
    wr_cols(0, 100);
    newFrameIn = 1'b0;
    wrEn  = 1'b1;
    wrPxl = pat(0, 100);
    #3;
    rstN = 1'b0;
    #1;
    check("arst_curCur", {cCR, cCG, cCB}, 24'd0);
    check("arst_prevPrev", {pPR, pPG, pPB}, 24'd0);
    check("arst_nextNext", {nNR, nNG, nNB}, 24'd0);
    check("arst_sameLine", {23'd0, sameLine}, 24'd1);
    check("arst_overflow", {23'd0, overflow}, 24'd0);
    check("arst_newFrameOut", {23'd0, newFrameOut}, 24'd0);
    wrEn = 1'b0;
    repeat (2) @(negedge pxlClk);
    rstN = 1'b1;
    curPxl = 8'd0;
    wrEn  = 1'b1;
    wrPxl = 24'h123456;
    @(negedge pxlClk);
    wrEn = 1'b0;
    @(negedge pxlClk);
    check("post_rst_write", {cCR, cCG, cCB}, 24'h123456);
    @(negedge pxlClk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
